// File: rtl/e1_buf_arb.sv
// Round-robin arbiter sharing one single-port RAM between N RX-write/TX-read buffer ports.
// Latency: strobe->RAM op 2 clk, TX strobe->rdy+data 4 clk; strobes while rdy=0 drop and pulse buf_ovf.
module e1_buf_arb #(
   parameter int N   = 2,
   parameter int MFW = 7,
   parameter int BW  = 2,
   localparam int UW = (N > 1) ? $clog2(N) : 1,
   localparam int AW = UW + 1 + BW + 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N*8-1:0]   buf_rx_data,
   input  logic [N*5-1:0]   buf_rx_ts,
   input  logic [N*4-1:0]   buf_rx_frame,
   input  logic [N*MFW-1:0] buf_rx_mf,
   input  logic [N-1:0]     buf_rx_we,
   output logic [N-1:0]     buf_rx_rdy,
   output logic [N*8-1:0]   buf_tx_data,
   input  logic [N*5-1:0]   buf_tx_ts,
   input  logic [N*4-1:0]   buf_tx_frame,
   input  logic [N*MFW-1:0] buf_tx_mf,
   input  logic [N-1:0]     buf_tx_re,
   output logic [N-1:0]     buf_tx_rdy,
   output logic [AW-1:0]    mem_addr,
   output logic [7:0]       mem_wdata,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [7:0]       mem_rdata,
   output logic [N-1:0]     buf_ovf
);

   localparam int RW = UW + 1;
   localparam int R  = 2 * N;

   logic [N-1:0]    pend_rx;
   logic [N-1:0]    pend_tx;
   logic [N-1:0]    busy_tx;
   logic [4:0]      rx_ts  [N];
   logic [3:0]      rx_fr  [N];
   logic [BW-1:0]   rx_mf  [N];
   logic [7:0]      rx_dat [N];
   logic [4:0]      tx_ts  [N];
   logic [3:0]      tx_fr  [N];
   logic [BW-1:0]   tx_mf  [N];

   logic [RW-1:0]   last_grant;
   logic [R-1:0]    pend;
   logic            gnt_vld;
   logic [RW-1:0]   gnt_idx;
   logic [UW-1:0]   gnt_unit;
   logic            gnt_dir;
   logic [AW-1:0]   gnt_addr;

   logic [N-1:0]    rx_cap;
   logic [N-1:0]    tx_cap;
   logic [N-1:0]    rx_ovf;
   logic [N-1:0]    tx_ovf;

   logic [UW-1:0]   iss_unit;
   logic            rd_vld;
   logic [UW-1:0]   rd_unit;
   logic            unused_mf;

   // Ready depends only on state, so there is no strobe-to-ready path.
   assign buf_rx_rdy = ~pend_rx;
   assign buf_tx_rdy = ~pend_tx & ~busy_tx;

   assign rx_cap = buf_rx_we & buf_rx_rdy;
   assign tx_cap = buf_tx_re & buf_tx_rdy;
   assign rx_ovf = buf_rx_we & ~buf_rx_rdy;
   assign tx_ovf = buf_tx_re & ~buf_tx_rdy;

   assign unused_mf = ^{buf_rx_mf, buf_tx_mf};

   always_comb begin
      pend = '0;
      for (int i = 0; i < N; i++) begin
         pend[2*i]   = pend_rx[i];
         pend[2*i+1] = pend_tx[i];
      end
   end

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= R; k++) begin
         if (!gnt_vld && pend[(int'(last_grant) + k) % R]) begin
            gnt_vld = 1'b1;
            gnt_idx = RW'((int'(last_grant) + k) % R);
         end
      end
   end

   assign gnt_unit = gnt_idx[RW-1:1];
   assign gnt_dir  = gnt_idx[0];

   always_comb begin
      gnt_addr = '0;
      if (gnt_dir)
         gnt_addr = {gnt_unit, 1'b1, tx_mf[gnt_unit], tx_fr[gnt_unit], tx_ts[gnt_unit]};
      else
         gnt_addr = {gnt_unit, 1'b0, rx_mf[gnt_unit], rx_fr[gnt_unit], rx_ts[gnt_unit]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            rx_ts[i]  <= '0;
            rx_fr[i]  <= '0;
            rx_mf[i]  <= '0;
            rx_dat[i] <= '0;
            tx_ts[i]  <= '0;
            tx_fr[i]  <= '0;
            tx_mf[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rx_cap[i]) begin
               rx_ts[i]  <= buf_rx_ts[5*i +: 5];
               rx_fr[i]  <= buf_rx_frame[4*i +: 4];
               rx_mf[i]  <= buf_rx_mf[MFW*i +: BW];
               rx_dat[i] <= buf_rx_data[8*i +: 8];
            end
            if (tx_cap[i]) begin
               tx_ts[i] <= buf_tx_ts[5*i +: 5];
               tx_fr[i] <= buf_tx_frame[4*i +: 4];
               tx_mf[i] <= buf_tx_mf[MFW*i +: BW];
            end
         end
      end
   end

   // A slot can never be captured and granted in the same cycle: capture needs
   // pend=0, grant needs pend=1. Likewise busy never sets and clears together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_rx <= '0;
         pend_tx <= '0;
         busy_tx <= '0;
         buf_ovf <= '0;
      end else begin
         buf_ovf <= rx_ovf | tx_ovf;
         for (int i = 0; i < N; i++) begin
            if (gnt_vld && gnt_idx == RW'(2*i))
               pend_rx[i] <= 1'b0;
            else if (rx_cap[i])
               pend_rx[i] <= 1'b1;

            if (gnt_vld && gnt_idx == RW'(2*i+1)) begin
               pend_tx[i] <= 1'b0;
               busy_tx[i] <= 1'b1;
            end else begin
               if (tx_cap[i])
                  pend_tx[i] <= 1'b1;
               if (rd_vld && rd_unit == UW'(i))
                  busy_tx[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= RW'(R - 1);
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         iss_unit   <= '0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         if (gnt_vld) begin
            last_grant <= gnt_idx;
            mem_addr   <= gnt_addr;
            mem_we     <= ~gnt_dir;
            mem_re     <= gnt_dir;
            iss_unit   <= gnt_unit;
            if (!gnt_dir)
               mem_wdata <= rx_dat[gnt_unit];
         end
      end
   end

   // Second pipeline stage lines up with mem_rdata; reset drops any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld      <= 1'b0;
         rd_unit     <= '0;
         buf_tx_data <= '0;
      end else begin
         rd_vld  <= mem_re;
         rd_unit <= iss_unit;
         for (int i = 0; i < N; i++) begin
            if (rd_vld && rd_unit == UW'(i))
               buf_tx_data[8*i +: 8] <= mem_rdata;
         end
      end
   end

endmodule
